// File: rtl/match_resp_reorder_if.sv
// match_resp_reorder_if: scheduler/channel/job-PE bus of the match response reorder buffer
interface match_resp_reorder_if #(
  parameter int NUM_CH = 8,
  parameter int LAZY_LEN = 4,
  parameter int TAG_BITS = 2,
  parameter int MATCH_LEN_WIDTH = 8,
  parameter int GID_BITS = 2
);
  logic req_group_fire;
  logic [LAZY_LEN-1:0] req_group_strb;
  logic req_group_ready;
  logic [GID_BITS-1:0] req_group_gid;
  logic [NUM_CH-1:0] resp_valid;
  logic [NUM_CH-1:0] resp_ready;
  logic [NUM_CH*GID_BITS-1:0] resp_gid;
  logic [NUM_CH*TAG_BITS-1:0] resp_tag;
  logic [NUM_CH*MATCH_LEN_WIDTH-1:0] resp_match_len;
  logic resp_group_valid;
  logic resp_group_ready;
  logic [LAZY_LEN*MATCH_LEN_WIDTH-1:0] resp_group_match_len;
  logic [GID_BITS:0] occupancy;
  logic err_orphan;
  modport master (
    output req_group_fire, req_group_strb, resp_valid, resp_gid, resp_tag, resp_match_len, resp_group_ready,
    input req_group_ready, req_group_gid, resp_ready, resp_group_valid, resp_group_match_len, occupancy, err_orphan
  );
  modport slave (
    input req_group_fire, req_group_strb, resp_valid, resp_gid, resp_tag, resp_match_len, resp_group_ready,
    output req_group_ready, req_group_gid, resp_ready, resp_group_valid, resp_group_match_len, occupancy, err_orphan
  );
endinterface

// File: rtl/match_resp_reorder.sv
// match_resp_reorder: in-order retire of out-of-order lane responses; MATCH_RESP_REORDER_TIMEOUT_EN adds a head watchdog
module match_resp_reorder #(
  parameter int NUM_CH = 8,
  parameter int LAZY_LEN = 4,
  parameter int TAG_BITS = 2,
  parameter int MATCH_LEN_WIDTH = 8,
  parameter int GROUP_DEPTH = 4,
  parameter int GID_BITS = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic rst,
`ifdef MATCH_RESP_REORDER_TIMEOUT_EN
  output logic err_timeout,
`endif
  match_resp_reorder_if.slave bus
);
  if (TAG_BITS != $clog2(LAZY_LEN) || GID_BITS != $clog2(GROUP_DEPTH) || GROUP_DEPTH < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("match_resp_reorder: inconsistent parameters");
  end
  logic [GROUP_DEPTH-1:0] busy_q, busy_d;
  logic [GROUP_DEPTH-1:0][LAZY_LEN-1:0] pending_q, pending_d;
  logic [GROUP_DEPTH-1:0][LAZY_LEN-1:0][MATCH_LEN_WIDTH-1:0] len_q, len_d;
  logic [GROUP_DEPTH-1:0][LAZY_LEN-1:0] hit;
  logic [GID_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [GID_BITS:0] count_q, count_d;
  logic err_orphan_q, err_orphan_d;
  logic [GID_BITS-1:0] ch_gid [NUM_CH];
  logic [TAG_BITS-1:0] ch_tag [NUM_CH];
  logic [MATCH_LEN_WIDTH-1:0] ch_len [NUM_CH];
  logic fire_ok, retire, head_done, expire;
  assign bus.req_group_ready = count_q != (GID_BITS+1)'(GROUP_DEPTH);
  assign bus.req_group_gid = wr_ptr_q;
  assign bus.resp_ready = {NUM_CH{~rst}};
  assign head_done = busy_q[rd_ptr_q] & ~|pending_q[rd_ptr_q];
  assign bus.resp_group_valid = head_done;
  assign bus.resp_group_match_len = len_q[rd_ptr_q];
  assign bus.occupancy = count_q;
  assign bus.err_orphan = err_orphan_q;
  assign fire_ok = bus.req_group_fire & bus.req_group_ready;
  assign retire = head_done & bus.resp_group_ready;
  // unpack the flat per-channel response fields
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_gid[c] = bus.resp_gid[c*GID_BITS +: GID_BITS];
      ch_tag[c] = bus.resp_tag[c*TAG_BITS +: TAG_BITS];
      ch_len[c] = bus.resp_match_len[c*MATCH_LEN_WIDTH +: MATCH_LEN_WIDTH];
    end
  end
  // slot updates: responses (lowest channel wins a lane), watchdog expiry, retire, allocate
  always_comb begin
    busy_d = busy_q;
    pending_d = pending_q;
    len_d = len_q;
    hit = '0;
    err_orphan_d = err_orphan_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.resp_valid[c]) begin
        if (busy_q[ch_gid[c]] && pending_q[ch_gid[c]][ch_tag[c]] && !hit[ch_gid[c]][ch_tag[c]]) begin
          hit[ch_gid[c]][ch_tag[c]] = 1'b1;
          len_d[ch_gid[c]][ch_tag[c]] = ch_len[c];
          pending_d[ch_gid[c]][ch_tag[c]] = 1'b0;
        end else begin
          err_orphan_d = 1'b1;
        end
      end
    end
    if (expire) pending_d[rd_ptr_q] = '0;
    if (retire) busy_d[rd_ptr_q] = 1'b0;
    if (fire_ok) begin
      busy_d[wr_ptr_q] = 1'b1;
      pending_d[wr_ptr_q] = bus.req_group_strb;
      len_d[wr_ptr_q] = '0;
    end
  end
  // pointer and occupancy bookkeeping; pointers wrap naturally at GROUP_DEPTH
  always_comb begin
    wr_ptr_d = fire_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = retire ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = count_q + (GID_BITS+1)'(fire_ok) - (GID_BITS+1)'(retire);
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      pending_q <= '0;
      len_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      pending_q <= pending_d;
      len_q <= len_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      err_orphan_q <= err_orphan_d;
    end
  end
`ifdef MATCH_RESP_REORDER_TIMEOUT_EN
  localparam int WD_BITS = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_BITS-1:0] wd_q, wd_d;
  logic err_timeout_q, err_timeout_d, head_wait;
  assign head_wait = busy_q[rd_ptr_q] & |pending_q[rd_ptr_q];
  assign expire = head_wait & (wd_q == WD_BITS'(TIMEOUT_CYCLES));
  assign err_timeout = err_timeout_q;
  // count cycles the head waits on lanes; restarts once the head has nothing pending
  always_comb begin
    wd_d = (head_wait & ~expire) ? wd_q + 1'b1 : '0;
    err_timeout_d = err_timeout_q | expire;
  end
  // watchdog registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      err_timeout_q <= err_timeout_d;
    end
  end
`else
  assign expire = 1'b0;
`endif
  a_fire_when_full: assert property (@(posedge clk) disable iff (rst) bus.req_group_fire |-> bus.req_group_ready);
endmodule

// File: tb/tb_match_resp_reorder.sv
// tb_match_resp_reorder: directed self-checking bench for match_resp_reorder
module tb_match_resp_reorder;
  localparam int TMO = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int passes = 0;
  match_resp_reorder_if bus ();
`ifdef MATCH_RESP_REORDER_TIMEOUT_EN
  logic err_timeout;
`endif
  match_resp_reorder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk),
    .rst(rst),
`ifdef MATCH_RESP_REORDER_TIMEOUT_EN
    .err_timeout(err_timeout),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_resp();
    bus.resp_valid = '0;
    bus.resp_gid = '0;
    bus.resp_tag = '0;
    bus.resp_match_len = '0;
  endtask

  task automatic set_resp(input int c, input int g, input int t, input int l);
    bus.resp_valid[c] = 1'b1;
    bus.resp_gid[c*2 +: 2] = 2'(g);
    bus.resp_tag[c*2 +: 2] = 2'(t);
    bus.resp_match_len[c*8 +: 8] = 8'(l);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_group_fire = 1'b0;
    bus.req_group_strb = '0;
    bus.resp_group_ready = 1'b0;
    clear_resp();
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_group_fire = 1'b0;
    bus.req_group_strb = '0;
    bus.resp_group_ready = 1'b0;
    clear_resp();
    step();
    step();
    checks++; if (bus.resp_ready !== 8'h00) $display("FAIL rst_resp_ready: got %h want 00", bus.resp_ready); else passes++;
    checks++; if (bus.req_group_ready !== 1'b1) $display("FAIL rst_req_ready: got %b want 1", bus.req_group_ready); else passes++;
    checks++; if (bus.req_group_gid !== 2'd0) $display("FAIL rst_gid: got %0d want 0", bus.req_group_gid); else passes++;
    checks++; if (bus.resp_group_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.resp_group_valid); else passes++;
    checks++; if (bus.occupancy !== 3'd0) $display("FAIL rst_occ: got %0d want 0", bus.occupancy); else passes++;
    checks++; if (bus.err_orphan !== 1'b0) $display("FAIL rst_orphan: got %b want 0", bus.err_orphan); else passes++;
    rst = 1'b0;
    #1;
    checks++; if (bus.resp_ready !== 8'hff) $display("FAIL post_rst_resp_ready: got %h want ff", bus.resp_ready); else passes++;
  endtask

  task automatic test_single_group();
    do_reset();
    checks++; if (bus.req_group_gid !== 2'd0) $display("FAIL single_gid: got %0d want 0", bus.req_group_gid); else passes++;
    bus.req_group_fire = 1'b1;
    bus.req_group_strb = 4'b1011;
    step();
    bus.req_group_fire = 1'b0;
    bus.req_group_strb = '0;
    checks++; if (bus.occupancy !== 3'd1) $display("FAIL single_occ1: got %0d want 1", bus.occupancy); else passes++;
    set_resp(0, 0, 0, 12);
    step();
    clear_resp();
    checks++; if (bus.resp_group_valid !== 1'b0) $display("FAIL single_early1: got %b want 0", bus.resp_group_valid); else passes++;
    set_resp(5, 0, 3, 7);
    step();
    clear_resp();
    checks++; if (bus.resp_group_valid !== 1'b0) $display("FAIL single_early2: got %b want 0", bus.resp_group_valid); else passes++;
    set_resp(2, 0, 1, 30);
    step();
    clear_resp();
    checks++; if (bus.resp_group_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", bus.resp_group_valid); else passes++;
    checks++; if (bus.resp_group_match_len !== 32'h07001e0c) $display("FAIL single_len: got %h want 07001e0c", bus.resp_group_match_len); else passes++;
    checks++; if (bus.err_orphan !== 1'b0) $display("FAIL single_orphan: got %b want 0", bus.err_orphan); else passes++;
    bus.resp_group_ready = 1'b1;
    step();
    bus.resp_group_ready = 1'b0;
    checks++; if (bus.occupancy !== 3'd0) $display("FAIL single_occ0: got %0d want 0", bus.occupancy); else passes++;
    checks++; if (bus.resp_group_valid !== 1'b0) $display("FAIL single_retired: got %b want 0", bus.resp_group_valid); else passes++;
    checks++; if (bus.req_group_gid !== 2'd1) $display("FAIL single_next_gid: got %0d want 1", bus.req_group_gid); else passes++;
  endtask

  task automatic test_out_of_order();
    do_reset();
    bus.req_group_fire = 1'b1;
    bus.req_group_strb = 4'b0001;
    step();
    step();
    bus.req_group_fire = 1'b0;
    bus.req_group_strb = '0;
    set_resp(4, 1, 0, 9);
    step();
    clear_resp();
    checks++; if (bus.resp_group_valid !== 1'b0) $display("FAIL ooo_wait_head: got %b want 0", bus.resp_group_valid); else passes++;
    set_resp(3, 0, 0, 4);
    step();
    clear_resp();
    checks++; if (bus.resp_group_valid !== 1'b1) $display("FAIL ooo_head_valid: got %b want 1", bus.resp_group_valid); else passes++;
    checks++; if (bus.resp_group_match_len !== 32'h00000004) $display("FAIL ooo_head_len: got %h want 00000004", bus.resp_group_match_len); else passes++;
    bus.resp_group_ready = 1'b1;
    step();
    checks++; if (bus.resp_group_valid !== 1'b1) $display("FAIL ooo_second_valid: got %b want 1", bus.resp_group_valid); else passes++;
    checks++; if (bus.resp_group_match_len !== 32'h00000009) $display("FAIL ooo_second_len: got %h want 00000009", bus.resp_group_match_len); else passes++;
    step();
    bus.resp_group_ready = 1'b0;
    checks++; if (bus.occupancy !== 3'd0) $display("FAIL ooo_occ0: got %0d want 0", bus.occupancy); else passes++;
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.req_group_gid !== 2'(i)) $display("FAIL full_gid%0d: got %0d want %0d", i, bus.req_group_gid, i); else passes++;
      bus.req_group_fire = 1'b1;
      bus.req_group_strb = '0;
      step();
    end
    bus.req_group_fire = 1'b0;
    checks++; if (bus.req_group_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", bus.req_group_ready); else passes++;
    checks++; if (bus.occupancy !== 3'd4) $display("FAIL full_occ: got %0d want 4", bus.occupancy); else passes++;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (bus.resp_group_valid !== 1'b1) $display("FAIL hold_valid%0d: got %b want 1", i, bus.resp_group_valid); else passes++;
      checks++; if (bus.resp_group_match_len !== 32'h0) $display("FAIL hold_len%0d: got %h want 0", i, bus.resp_group_match_len); else passes++;
    end
    bus.resp_group_ready = 1'b1;
    repeat (4) step();
    checks++; if (bus.occupancy !== 3'd0) $display("FAIL drain_occ: got %0d want 0", bus.occupancy); else passes++;
    checks++; if (bus.resp_group_valid !== 1'b0) $display("FAIL drain_valid: got %b want 0", bus.resp_group_valid); else passes++;
    for (int i = 0; i < 6; i++) begin
      checks++; if (bus.req_group_gid !== 2'(i % 4)) $display("FAIL wrap_gid%0d: got %0d want %0d", i, bus.req_group_gid, i % 4); else passes++;
      if (i > 0) begin
        checks++; if (bus.occupancy !== 3'd1) $display("FAIL wrap_occ%0d: got %0d want 1", i, bus.occupancy); else passes++;
      end
      bus.req_group_fire = 1'b1;
      step();
    end
    bus.req_group_fire = 1'b0;
    step();
    bus.resp_group_ready = 1'b0;
    checks++; if (bus.occupancy !== 3'd0) $display("FAIL wrap_occ_end: got %0d want 0", bus.occupancy); else passes++;
  endtask

  task automatic test_collision();
    do_reset();
    bus.req_group_fire = 1'b1;
    bus.req_group_strb = 4'b0100;
    step();
    bus.req_group_fire = 1'b0;
    bus.req_group_strb = '0;
    set_resp(1, 0, 2, 20);
    set_resp(6, 0, 2, 40);
    step();
    clear_resp();
    checks++; if (bus.resp_group_valid !== 1'b1) $display("FAIL coll_valid: got %b want 1", bus.resp_group_valid); else passes++;
    checks++; if (bus.resp_group_match_len[23:16] !== 8'd20) $display("FAIL coll_lane2: got %0d want 20", bus.resp_group_match_len[23:16]); else passes++;
    checks++; if (bus.err_orphan !== 1'b1) $display("FAIL coll_orphan: got %b want 1", bus.err_orphan); else passes++;
    step();
    step();
    checks++; if (bus.err_orphan !== 1'b1) $display("FAIL coll_sticky: got %b want 1", bus.err_orphan); else passes++;
  endtask

  task automatic test_same_cycle_alloc();
    do_reset();
    bus.req_group_fire = 1'b1;
    bus.req_group_strb = 4'b0001;
    set_resp(0, 0, 0, 3);
    step();
    bus.req_group_fire = 1'b0;
    bus.req_group_strb = '0;
    clear_resp();
    checks++; if (bus.err_orphan !== 1'b1) $display("FAIL alloc_orphan: got %b want 1", bus.err_orphan); else passes++;
    checks++; if (bus.resp_group_valid !== 1'b0) $display("FAIL alloc_valid: got %b want 0", bus.resp_group_valid); else passes++;
  endtask

  task automatic test_orphan_reset();
    do_reset();
    set_resp(3, 3, 0, 1);
    step();
    clear_resp();
    checks++; if (bus.err_orphan !== 1'b1) $display("FAIL idle_orphan: got %b want 1", bus.err_orphan); else passes++;
    bus.req_group_fire = 1'b1;
    bus.req_group_strb = 4'b0011;
    step();
    bus.req_group_fire = 1'b0;
    bus.req_group_strb = '0;
    set_resp(0, 0, 0, 5);
    step();
    clear_resp();
    checks++; if (bus.occupancy !== 3'd1) $display("FAIL mid_occ: got %0d want 1", bus.occupancy); else passes++;
    rst = 1'b1;
    set_resp(1, 0, 1, 6);
    step();
    clear_resp();
    checks++; if (bus.occupancy !== 3'd0) $display("FAIL mrst_occ: got %0d want 0", bus.occupancy); else passes++;
    checks++; if (bus.err_orphan !== 1'b0) $display("FAIL mrst_orphan: got %b want 0", bus.err_orphan); else passes++;
    checks++; if (bus.resp_ready !== 8'h00) $display("FAIL mrst_resp_ready: got %h want 00", bus.resp_ready); else passes++;
    checks++; if (bus.req_group_gid !== 2'd0) $display("FAIL mrst_gid: got %0d want 0", bus.req_group_gid); else passes++;
    checks++; if (bus.resp_group_valid !== 1'b0) $display("FAIL mrst_valid: got %b want 0", bus.resp_group_valid); else passes++;
    rst = 1'b0;
    #1;
    checks++; if (bus.resp_ready !== 8'hff) $display("FAIL mrst_resp_ready_after: got %h want ff", bus.resp_ready); else passes++;
    set_resp(1, 0, 1, 6);
    step();
    clear_resp();
    checks++; if (bus.err_orphan !== 1'b1) $display("FAIL stale_orphan: got %b want 1", bus.err_orphan); else passes++;
    checks++; if (bus.resp_group_valid !== 1'b0) $display("FAIL stale_valid: got %b want 0", bus.resp_group_valid); else passes++;
  endtask

`ifdef MATCH_RESP_REORDER_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    bus.req_group_fire = 1'b1;
    bus.req_group_strb = 4'b0011;
    step();
    bus.req_group_fire = 1'b0;
    bus.req_group_strb = '0;
    set_resp(0, 0, 0, 5);
    step();
    clear_resp();
    repeat (TMO - 1) step();
    checks++; if (bus.resp_group_valid !== 1'b0) $display("FAIL tmo_early: got %b want 0", bus.resp_group_valid); else passes++;
    checks++; if (err_timeout !== 1'b0) $display("FAIL tmo_err_early: got %b want 0", err_timeout); else passes++;
    step();
    checks++; if (bus.resp_group_valid !== 1'b1) $display("FAIL tmo_valid: got %b want 1", bus.resp_group_valid); else passes++;
    checks++; if (bus.resp_group_match_len !== 32'h00000005) $display("FAIL tmo_len: got %h want 00000005", bus.resp_group_match_len); else passes++;
    checks++; if (err_timeout !== 1'b1) $display("FAIL tmo_err: got %b want 1", err_timeout); else passes++;
    checks++; if (bus.err_orphan !== 1'b0) $display("FAIL tmo_orphan_pre: got %b want 0", bus.err_orphan); else passes++;
    set_resp(2, 0, 1, 8);
    step();
    clear_resp();
    checks++; if (bus.err_orphan !== 1'b1) $display("FAIL tmo_late_orphan: got %b want 1", bus.err_orphan); else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_single_group();
    test_out_of_order();
    test_full_wrap();
    test_collision();
    test_same_cycle_alloc();
    test_orphan_reset();
`ifdef MATCH_RESP_REORDER_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
